// File: rtl/exu_arbiter_if.sv
// Client-side bundle of the EXU arbiter: two request channels and two response channels.
// The arbiter takes the slave view; clients (or a bench) take the master view.
interface exu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 10
);
  logic            req0_valid;
  logic            req0_ready;
  logic [OPW-1:0]  req0_opcode;
  logic [XLEN-1:0] req0_src1;
  logic [XLEN-1:0] req0_src2;
  logic            req1_valid;
  logic            req1_ready;
  logic [OPW-1:0]  req1_opcode;
  logic [XLEN-1:0] req1_src1;
  logic [XLEN-1:0] req1_src2;
  logic            resp0_valid;
  logic            resp0_ready;
  logic [XLEN-1:0] resp0_res;
  logic            resp1_valid;
  logic            resp1_ready;
  logic [XLEN-1:0] resp1_res;

  modport slave (
    input  req0_valid, req0_opcode, req0_src1, req0_src2,
    input  req1_valid, req1_opcode, req1_src1, req1_src2,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_res, resp1_valid, resp1_res
  );

  modport master (
    output req0_valid, req0_opcode, req0_src1, req0_src2,
    output req1_valid, req1_opcode, req1_src1, req1_src2,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_res, resp1_valid, resp1_res
  );
endinterface

// File: rtl/exu_arbiter.sv
// Round-robin arbiter that time-shares one combinational EXU between two clients:
// accept in IDLE, drive the EXU in EXEC, hold the registered result in RESP.
module exu_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 10
) (
  input  logic            clk,
  input  logic            rst,
  exu_arbiter_if.slave    cl,
  output logic [OPW-1:0]  exu_opcode,
  output logic [XLEN-1:0] exu_src1,
  output logic [XLEN-1:0] exu_src2,
  input  logic [XLEN-1:0] exu_res,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic [1:0] resp_ready;
  logic       active;

  assign req_valid  = {cl.req1_valid, cl.req0_valid};
  assign resp_ready = {cl.resp1_ready, cl.resp0_ready};

  // A client wins if it is alone, or if the other client was served last.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      localparam logic ME = 1'(gi);
      assign grant[gi] = req_valid[gi] & (~req_valid[1-gi] | (last_grant_q != ME));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    opcode_d     = opcode_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    res_d        = res_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = grant[1];
          last_grant_d = grant[1];
          opcode_d     = grant[1] ? cl.req1_opcode : cl.req0_opcode;
          src1_d       = grant[1] ? cl.req1_src1   : cl.req0_src1;
          src2_d       = grant[1] ? cl.req1_src2   : cl.req0_src2;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_d   = exu_res;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      opcode_q     <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      opcode_q     <= opcode_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      res_q        <= res_d;
    end
  end

  // Outputs are masked while rst is high so nothing leaks out during the reset cycle.
  assign active         = ~rst;
  assign cl.req0_ready  = active & (state_q == IDLE) & grant[0];
  assign cl.req1_ready  = active & (state_q == IDLE) & grant[1];
  assign cl.resp0_valid = active & (state_q == RESP) & ~owner_q;
  assign cl.resp1_valid = active & (state_q == RESP) &  owner_q;
  assign cl.resp0_res   = res_q;
  assign cl.resp1_res   = res_q;

  // Zero opcode outside EXEC keeps the shared EXU output at 0.
  assign exu_opcode = (active && state_q == EXEC) ? opcode_q : '0;
  assign exu_src1   = src1_q;
  assign exu_src2   = src2_q;
  assign busy       = active & (state_q != IDLE);

endmodule

// File: tb/tb_exu_arbiter.sv
// Directed bench for exu_arbiter with a small EXU model covering the ops it uses.
// Inputs change 1 time unit after the rising edge; outputs are checked after a further settle.
module tb_exu_arbiter;

  localparam int XLEN = 32;
  localparam int OPW  = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [OPW-1:0]  exu_opcode;
  logic [XLEN-1:0] exu_src1, exu_src2, exu_res;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  exu_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) cl ();

  exu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cl         (cl.slave),
    .exu_opcode (exu_opcode),
    .exu_src1   (exu_src1),
    .exu_src2   (exu_src2),
    .exu_res    (exu_res),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference EXU: one-hot opcode, 0 when no function bit is set.
  always_comb begin
    exu_res = '0;
    case (exu_opcode)
      10'h001: exu_res = exu_src1 + exu_src2;
      10'h002: exu_res = exu_src1 - exu_src2;
      10'h020: exu_res = (exu_src1 < exu_src2) ? 32'd1 : 32'd0;
      10'h080: exu_res = exu_src1 << exu_src2[4:0];
      10'h100: exu_res = $signed(exu_src1) >>> exu_src2[4:0];
      default: exu_res = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cl.req0_valid  = 1'b0; cl.req0_opcode = '0; cl.req0_src1 = '0; cl.req0_src2 = '0;
    cl.req1_valid  = 1'b0; cl.req1_opcode = '0; cl.req1_src1 = '0; cl.req1_src2 = '0;
    cl.resp0_ready = 1'b0; cl.resp1_ready = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    // Reset state, with a request pending that must not be accepted.
    cl.req0_valid = 1'b1;
    tick();
    tick();
    check("rst_ready0", 32'(cl.req0_ready), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_resp0",  32'(cl.resp0_valid), 32'd0);
    check("rst_exu_op", 32'(exu_opcode), 32'd0);
    rst = 1'b0;

    // Single add on client 0.
    cl.req0_opcode = 10'h001; cl.req0_src1 = 32'd5; cl.req0_src2 = 32'd7;
    cl.resp0_ready = 1'b1;
    #1;
    check("add_ready0", 32'(cl.req0_ready), 32'd1);
    check("add_idle_op", 32'(exu_opcode), 32'd0);
    tick();
    cl.req0_valid = 1'b0;
    #1;
    check("add_busy", 32'(busy), 32'd1);
    check("add_exec_op", 32'(exu_opcode), 32'h001);
    check("add_exec_resp0", 32'(cl.resp0_valid), 32'd0);
    tick();
    check("add_resp0", 32'(cl.resp0_valid), 32'd1);
    check("add_resp1", 32'(cl.resp1_valid), 32'd0);
    check("add_res", cl.resp0_res, 32'd12);
    check("add_resp_op", 32'(exu_opcode), 32'd0);
    $display("txn add client0 res=%h", cl.resp0_res);
    tick();
    check("add_done_busy", 32'(busy), 32'd0);

    // Single sll on client 1; opcode passes through exactly in EXEC.
    cl.req1_valid = 1'b1; cl.req1_opcode = 10'h080; cl.req1_src1 = 32'd3; cl.req1_src2 = 32'd4;
    cl.resp1_ready = 1'b1;
    #1;
    check("sll_ready1", 32'(cl.req1_ready), 32'd1);
    check("sll_ready0", 32'(cl.req0_ready), 32'd0);
    tick();
    cl.req1_valid = 1'b0;
    #1;
    check("sll_exec_op", 32'(exu_opcode), 32'h080);
    check("sll_exec_src1", exu_src1, 32'd3);
    tick();
    check("sll_resp1", 32'(cl.resp1_valid), 32'd1);
    check("sll_resp0", 32'(cl.resp0_valid), 32'd0);
    check("sll_res", cl.resp1_res, 32'h30);
    check("sll_resp_op", 32'(exu_opcode), 32'd0);
    $display("txn sll client1 res=%h", cl.resp1_res);
    tick();

    // Tie after reset, then 12 back-to-back ops with both clients always valid.
    reset_dut();
    cl.req0_valid = 1'b1; cl.req0_opcode = 10'h002; cl.req0_src1 = 32'd3; cl.req0_src2 = 32'd5;
    cl.req1_valid = 1'b1; cl.req1_opcode = 10'h020; cl.req1_src1 = 32'd3; cl.req1_src2 = 32'd5;
    cl.resp0_ready = 1'b1; cl.resp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      logic who;
      who = 1'(i % 2);
      check("rr_grant0", 32'(cl.req0_ready), who ? 32'd0 : 32'd1);
      check("rr_grant1", 32'(cl.req1_ready), who ? 32'd1 : 32'd0);
      tick();
      check("rr_exec_op", 32'(exu_opcode), who ? 32'h020 : 32'h002);
      check("rr_exec_ready", 32'({cl.req1_ready, cl.req0_ready}), 32'd0);
      tick();
      check("rr_resp0", 32'(cl.resp0_valid), who ? 32'd0 : 32'd1);
      check("rr_resp1", 32'(cl.resp1_valid), who ? 32'd1 : 32'd0);
      check("rr_res", who ? cl.resp1_res : cl.resp0_res, who ? 32'd1 : 32'hFFFFFFFE);
      check("rr_resp_ready", 32'({cl.req1_ready, cl.req0_ready}), 32'd0);
      $display("txn rr op=%0d client%0d res=%h", i, who, who ? cl.resp1_res : cl.resp0_res);
      tick();
    end
    clear_inputs();
    #1;

    // Backpressure on client 0 while client 1 waits; last grant was client 1.
    cl.req0_valid = 1'b1; cl.req0_opcode = 10'h100; cl.req0_src1 = 32'h80000000; cl.req0_src2 = 32'd4;
    cl.req1_valid = 1'b1; cl.req1_opcode = 10'h001; cl.req1_src1 = 32'd1; cl.req1_src2 = 32'd2;
    #1;
    check("bp_ready0", 32'(cl.req0_ready), 32'd1);
    tick();
    cl.req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_resp0", 32'(cl.resp0_valid), 32'd1);
      check("bp_res", cl.resp0_res, 32'hF8000000);
      check("bp_ready", 32'({cl.req1_ready, cl.req0_ready}), 32'd0);
      tick();
    end
    cl.resp0_ready = 1'b1;
    #1;
    check("bp_release_resp0", 32'(cl.resp0_valid), 32'd1);
    $display("txn sra client0 res=%h", cl.resp0_res);
    tick();
    check("bp_resume_ready1", 32'(cl.req1_ready), 32'd1);
    check("bp_resume_busy", 32'(busy), 32'd0);
    clear_inputs();
    #1;

    // Reset during EXEC drops the operation and restores the req0 tie preference.
    cl.req0_valid = 1'b1; cl.req0_opcode = 10'h001; cl.req0_src1 = 32'd1; cl.req0_src2 = 32'd1;
    cl.resp0_ready = 1'b1;
    #1;
    check("mid_ready0", 32'(cl.req0_ready), 32'd1);
    tick();
    cl.req0_valid = 1'b0;
    #1;
    check("mid_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_op", 32'(exu_opcode), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_after_busy", 32'(busy), 32'd0);
    check("mid_after_resp", 32'({cl.resp1_valid, cl.resp0_valid}), 32'd0);
    tick();
    check("mid_no_resp", 32'({cl.resp1_valid, cl.resp0_valid}), 32'd0);
    cl.req0_valid = 1'b1;
    cl.req1_valid = 1'b1;
    #1;
    check("mid_tie_ready0", 32'(cl.req0_ready), 32'd1);
    check("mid_tie_ready1", 32'(cl.req1_ready), 32'd0);
    $display("txn reset-mid-op tie ready0=%0d ready1=%0d", cl.req0_ready, cl.req1_ready);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_arbiter.md
# exu_arbiter

Two-requester arbiter and sequencer for the shared combinational EXU. It accepts ALU operations from two clients over valid/ready handshakes, selects one by round-robin, and drives the EXU for one cycle. It registers the result and returns it to the issuing client on a per-client response handshake. The block sits between the decode/issue logic and the single EXU instance, so one ALU serves both the core pipeline and a secondary client such as address generation.

## Interface
- XLEN, 32, operand/result width
- OPW, 10, opcode width (one bit per ALU function, same encoding as EXU `opcode`)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid / req1_valid  in  1  client N presents an operation
- req0_ready / req1_ready  out  1  client N operation accepted this cycle
- req0_opcode / req1_opcode  in  OPW  one-hot ALU function
- req0_src1 / req1_src1  in  XLEN  operand 1
- req0_src2 / req1_src2  in  XLEN  operand 2
- resp0_valid / resp1_valid  out  1  result available for client N
- resp0_ready / resp1_ready  in  1  client N consumes result
- resp0_res / resp1_res  out  XLEN  result (both driven from one result register)
- exu_opcode  out  OPW  to EXU `opcode`
- exu_src1 / exu_src2  out  XLEN  to EXU `src1` / `src2`
- exu_res  in  XLEN  from EXU `res`
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: the only state in which requests are accepted.
  - EXEC: latched operation is driven to the EXU; `exu_res` is captured into the result register at the end of the cycle.
  - RESP: result is held for the owner.
- Grant logic (IDLE only):
  - grantN = reqN_valid & (!req_other_valid | last_grant != N).
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high, and only when its valid is high.
- On accept:
  - Latch opcode, src1, src2 and owner; set last_grant = owner; go to EXEC.
- EXEC:
  - exu_opcode = latched opcode; exu_src1/2 = latched operands.
  - Capture exu_res into res_q; go to RESP.
- In IDLE and RESP, exu_opcode = 0, so the EXU output is 0. exu_src1/2 keep the latched values.
- RESP:
  - resp<owner>_valid = 1; the other resp_valid = 0.
  - On resp<owner>_ready go to IDLE. Otherwise hold, with res_q stable.
- Opcode contents are not checked; the arbiter passes them through. Opcode 0 yields result 0, per EXU behaviour.
- Reset values: state IDLE; last_grant = 1, so req0 wins the first tie; owner 0; opcode/operand latches 0; res_q 0.
- Output values under reset: resp*_valid 0, req*_ready 0 during rst, busy 0, exu_opcode 0.

## Timing
- Cycle A: reqN_valid & reqN_ready; state becomes EXEC at the edge.
- Cycle A+1: EXU driven; result captured at the edge.
- Cycle A+2: respN_valid = 1, respN_res valid.
- Latency is 2 cycles from accept to response valid.
- If respN_ready is high in A+2, the next accept is possible in A+3. Minimum issue interval is 3 cycles.
- req*_ready is low in EXEC and RESP regardless of requests. Requests may stay asserted and must hold stable until accepted.
- Response backpressure holds the FSM in RESP indefinitely and blocks both clients.
- rst in any state: next cycle is IDLE, any pending response is dropped (resp valid 0), last_grant = 1.
- Simultaneous events:
  - Both valid in IDLE: the round-robin loser stays unaccepted and is served on the next IDLE cycle if still valid.
  - A request arriving in RESP while a response fires: it waits one cycle and is accepted in IDLE.

## Test plan
- Single add: req0 opcode=10'h001, src1=5, src2=7 → req0_ready in cycle A; resp0_valid in A+2 with res=12; resp1_valid never high.
- Tie after reset: both valid; req0 sub (10'h002, 3, 5) and req1 sltu (10'h020, 3, 5) → req0 served first with res=32'hFFFFFFFE. Then req1 is served with res=1; its accept falls in A+3, response in A+5.
- Fairness: both clients valid continuously for 12 ops with responses always ready → grants alternate 0,1,0,1…; each accept is 3 cycles apart.
- Backpressure: op sra (10'h100, 32'h80000000, 4) with resp0_ready=0 for 5 cycles → resp0_valid stays 1 and res stays 32'hF8000000. req0_ready and req1_ready stay 0 throughout; accept resumes the cycle after ready.
- EXU idle drive: during IDLE and RESP cycles exu_opcode=0. During EXEC exu_opcode equals the latched opcode exactly (e.g. 10'h080 sll).
- Reset mid-op: assert rst in EXEC → next cycle busy=0 and resp*_valid=0, with no result delivered. A subsequent tie is granted to req0.
